// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Greedy coin-change dispenser. Takes a change amount in cents
//               and releases it one coin per eject slot, largest denomination
//               first ($5, $1, 25c, 10c, 5c). Reports per-denomination counts,
//               the undispensable remainder and a short-change flag.
// Build macro : COIN_INVENTORY_EN - when defined, each denomination has a
//               finite inventory (INV_INIT coins) that the greedy choice
//               respects, reloadable with refill while idle. When undefined,
//               coins are unlimited and there is no refill port.
// Ports       : clk, rst_n           clock / async active-low reset
//               start, amount_cents  dispense request (sampled while idle)
//               refill               inventory reload (COIN_INVENTORY_EN)
//               busy, done           request in progress / finish pulse
//               coin_eject, coin_type  one pulse per coin, 1=5c .. 5=$5
//               cnt_*                coins of each type for this request
//               remainder_cents, short  leftover amount at done
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int AMT_W     = 13,
    parameter int CNT_W     = 8,
    parameter int EJECT_GAP = 2
`ifdef COIN_INVENTORY_EN
    ,
    parameter int INV_INIT  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount_cents,
`ifdef COIN_INVENTORY_EN
    input  logic             refill,
`endif
    output logic             busy,
    output logic             done,
    output logic             coin_eject,
    output logic [2:0]       coin_type,
    output logic [CNT_W-1:0] cnt_nickel,
    output logic [CNT_W-1:0] cnt_dime,
    output logic [CNT_W-1:0] cnt_quarter,
    output logic [CNT_W-1:0] cnt_dollar,
    output logic [CNT_W-1:0] cnt_five,
    output logic [AMT_W-1:0] remainder_cents,
    output logic             short
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DISPENSE = 2'd1;
    localparam logic [1:0] c_GAP      = 2'd2;

    // Coin value indexed by coin_type code.
    localparam logic [AMT_W-1:0] c_VAL [1:5] = '{AMT_W'(5), AMT_W'(10), AMT_W'(25),
                                                 AMT_W'(100), AMT_W'(500)};

    localparam int              c_GAP_W    = (EJECT_GAP > 1) ? $clog2(EJECT_GAP + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (EJECT_GAP > 0) ? c_GAP_W'(EJECT_GAP - 1)
                                                                : '0;

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_eject;
    logic [2:0]         r_type;
    logic [AMT_W-1:0]   r_rem;
    logic [AMT_W-1:0]   r_remainder;
    logic               r_short;
    logic [c_GAP_W-1:0] r_gap;
    logic [CNT_W-1:0]   r_cnt [1:5];

    logic [5:1]         w_avail;
    logic [2:0]         w_type;
    logic [AMT_W-1:0]   w_val;

`ifdef COIN_INVENTORY_EN
    localparam int c_INV_W = (INV_INIT > 0) ? $clog2(INV_INIT + 1) : 1;
    localparam logic [c_INV_W-1:0] c_INV_LOAD = c_INV_W'(INV_INIT);

    logic [c_INV_W-1:0] r_inv [1:5];

    always_comb begin
        w_avail = '0;
        for (int i = 1; i <= 5; i++) begin
            w_avail[i] = (r_inv[i] != '0);
        end
    end
`else
    assign w_avail = '1;
`endif

    // Greedy pick: ascending scan, so the last qualifying coin (the largest)
    // wins. w_type == 0 means nothing more can be paid out.
    always_comb begin
        w_type = 3'd0;
        w_val  = '0;
        for (int i = 1; i <= 5; i++) begin
            if (r_rem >= c_VAL[i] && w_avail[i]) begin
                w_type = 3'(i);
                w_val  = c_VAL[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_eject     <= 1'b0;
            r_type      <= 3'd0;
            r_rem       <= '0;
            r_remainder <= '0;
            r_short     <= 1'b0;
            r_gap       <= '0;
            for (int i = 1; i <= 5; i++) begin
                r_cnt[i] <= '0;
`ifdef COIN_INVENTORY_EN
                r_inv[i] <= c_INV_LOAD;
`endif
            end
        end else begin
            // Pulses default low every cycle.
            r_done  <= 1'b0;
            r_eject <= 1'b0;
            r_type  <= 3'd0;
            case (r_state)
                c_IDLE: begin
`ifdef COIN_INVENTORY_EN
                    if (refill) begin
                        for (int i = 1; i <= 5; i++) begin
                            r_inv[i] <= c_INV_LOAD;
                        end
                    end
`endif
                    if (start) begin
                        r_rem       <= amount_cents;
                        r_remainder <= '0;
                        r_short     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_DISPENSE;
                        for (int i = 1; i <= 5; i++) begin
                            r_cnt[i] <= '0;
                        end
                    end
                end
                c_DISPENSE: begin
                    if (w_type != 3'd0) begin
                        r_eject <= 1'b1;
                        r_type  <= w_type;
                        r_rem   <= r_rem - w_val;
                        for (int i = 1; i <= 5; i++) begin
                            if (w_type == 3'(i)) begin
                                // Count saturates; the coin is still released.
                                if (r_cnt[i] != '1) begin
                                    r_cnt[i] <= r_cnt[i] + 1'b1;
                                end
`ifdef COIN_INVENTORY_EN
                                r_inv[i] <= r_inv[i] - 1'b1;
`endif
                            end
                        end
                        if (EJECT_GAP > 0) begin
                            r_gap   <= c_GAP_LOAD;
                            r_state <= c_GAP;
                        end
                    end else begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_remainder <= r_rem;
                        r_short     <= (r_rem != '0);
                        r_state     <= c_IDLE;
                    end
                end
                c_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= c_DISPENSE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign coin_eject      = r_eject;
    assign coin_type       = r_type;
    assign cnt_nickel      = r_cnt[1];
    assign cnt_dime        = r_cnt[2];
    assign cnt_quarter     = r_cnt[3];
    assign cnt_dollar      = r_cnt[4];
    assign cnt_five        = r_cnt[5];
    assign remainder_cents = r_remainder;
    assign short           = r_short;

endmodule
`default_nettype wire
